// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: two-write / two-read register file with same-cycle
// bypass and a per-register pending-write scoreboard for long-latency ops.
// Register 0 and addresses at or above DEPTH read as zero and ignore writes/marks.
module regfile_scoreboard #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_pend_a,
    output logic             rd_pend_b,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             mark_valid,
    input  logic [AW-1:0]    mark_addr,
    output logic [AW:0]      pend_count,
    output logic             w1_err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [AW:0]      pend_count_q, pend_count_d;
    logic             w1_err_q, w1_err_d;
    logic             cnt_inc, cnt_dec;

    // Read path: port 0 bypass beats port 1 bypass beats the stored value.
    // Addresses outside 1..DEPTH-1 never match any slot, so they read zero.
    function automatic logic [WIDTH-1:0] read_data(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                if (we0 && waddr0 == addr)      r = wdata0;
                else if (we1 && waddr1 == addr) r = wdata1;
                else                            r = mem_q[i];
            end
        end
        return r;
    endfunction

    // A completing port-1 write hides the pending bit in the same cycle so
    // decode never stalls on a value it is already receiving via bypass.
    function automatic logic read_pend(input logic [AW-1:0] addr);
        logic p;
        p = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (addr == AW'(i)) p = pend_q[i];
        end
        return p && !(we1 && waddr1 == addr);
    endfunction

    // Combinational read ports with bypass and pending status
    always_comb begin
        rd_data_a = read_data(rd_addr_a);
        rd_data_b = read_data(rd_addr_b);
        rd_pend_a = read_pend(rd_addr_a);
        rd_pend_b = read_pend(rd_addr_b);
    end

    // Next-state for array, scoreboard, counter and error pulse
    always_comb begin
        mem_d    = mem_q;
        pend_d   = pend_q;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        w1_err_d = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            // Port 0 is applied last so it wins an address conflict.
            if (we1 && waddr1 == AW'(i)) mem_d[i] = wdata1;
            if (we0 && waddr0 == AW'(i)) mem_d[i] = wdata0;
            // A new issue supersedes a completing one on the same register.
            if (mark_valid && mark_addr == AW'(i)) begin
                pend_d[i] = 1'b1;
                if (!pend_q[i]) cnt_inc = 1'b1;
            end else if (we1 && waddr1 == AW'(i)) begin
                pend_d[i] = 1'b0;
                if (pend_q[i]) cnt_dec = 1'b1;
            end
            if (we1 && waddr1 == AW'(i) && !pend_q[i]) w1_err_d = 1'b1;
        end
        mem_d[0]     = '0;
        pend_d[0]    = 1'b0;
        pend_count_d = pend_count_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            pend_q       <= '0;
            pend_count_q <= '0;
            w1_err_q     <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            pend_q       <= pend_d;
            pend_count_q <= pend_count_d;
            w1_err_q     <= w1_err_d;
        end
    end

    assign pend_count = pend_count_q;
    assign w1_err     = w1_err_q;

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the pipelined datapath with two write ports, two combinational read ports, same-cycle write-to-read bypass and a per-register pending-write scoreboard. Port 0 is the in-order writeback stage. Port 1 is the long-latency multiply/divide result path. Decode uses the scoreboard to stall on operands whose writes are still outstanding. Register 0 is hardwired to zero.

## Interface
Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (2..256, need not be a power of two)
- AW, clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr_a, rd_addr_b  in  AW  read addresses
- rd_data_a, rd_data_b  out  WIDTH  read data (combinational, bypassed)
- rd_pend_a, rd_pend_b  out  1  pending status of read addresses (combinational)
- we0  in  1  write enable, port 0 (writeback)
- waddr0  in  AW  write address, port 0
- wdata0  in  WIDTH  write data, port 0
- we1  in  1  write enable, port 1 (mul/div result); also clears pending
- waddr1  in  AW  write address, port 1
- wdata1  in  WIDTH  write data, port 1
- mark_valid  in  1  issue of a long-latency op; sets pending
- mark_addr  in  AW  destination being marked
- pend_count  out  AW+1  registered count of pending registers
- w1_err  out  1  registered one-cycle pulse: port-1 write to a non-pending register

## Operation
- Reset (rst_n low, asynchronous): all registers 0, all pending bits 0, pend_count 0, w1_err 0.
- An address is invalid if it is 0 or ≥ DEPTH.
- Writes to invalid addresses are dropped.
- Reads of invalid addresses return 0 with pending 0.
- Marks of invalid addresses are ignored.
- Write: on a rising edge, if weN and the address is valid, the register takes wdataN.
- If both ports write the same valid address in one cycle, port 0 wins. This applies to both array and bypass.
- Read (per port, valid address), in priority order:
  - we0 and waddr0 match → wdata0
  - else we1 and waddr1 match → wdata1
  - else stored value
- Scoreboard, per register, next state of pending[i]:
  - set if mark_valid and mark_addr = i
  - else cleared if we1 and waddr1 = i
  - else held
  - Set wins over clear on the same address in the same cycle, because the new issue supersedes the old one.
- Port 0 writes never touch pending bits.
- rd_pend_x = pending[addr] and not (we1 and waddr1 = addr). A same-cycle completion is visible immediately, matching the bypassed data.
- Marking an already-pending register leaves it pending. pend_count is unchanged.
- pend_count: registered counter.
  - +1 when a mark sets a previously clear bit.
  - −1 when a port-1 write clears a set bit (and no set on that address).
  - Both in one cycle on different addresses: net 0.
  - Invariant: always equals the popcount of pending.
- w1_err: pulses high for one cycle after any edge where we1 targets a valid address whose pending bit was 0. The write is still performed.

## Timing
- Read data and rd_pend are combinational from addresses, write ports and state: zero latency, including same-cycle bypass.
- Write-to-array latency: 1 edge. Mark-to-pending latency: 1 edge. rd_pend goes high the cycle after mark_valid.
- pend_count and w1_err update 1 edge after the causing event.
- Reset assertion mid-operation clears all state immediately, regardless of clk. Writes and marks presented during reset are lost.
- Reset deassertion is synchronised externally. The first rising edge after deassertion may perform a write.
- No combinational path from any input to pend_count or w1_err.

## Test plan
- Reset/zero:
  - Stimulus: write 0xDEADBEEF to r0 via both ports, then read r0; pulse rst_n low mid-cycle after filling r5.
  - Required: rd_data 0, pend 0; after reset r5 reads 0 without a clock edge and pend_count is 0.
- Bypass and conflict:
  - Stimulus: we0 r7 = 0x11, we1 r7 = 0x22 in the same cycle, reading r7 on both ports.
  - Required: 0x11 that cycle and 0x11 after the edge.
  - Stimulus: we1 alone r9 = 0x33.
  - Required: read r9 returns 0x33 in the same cycle.
- Scoreboard lifecycle:
  - Stimulus: mark r4.
  - Required: rd_pend r4 high next cycle, pend_count 1.
  - Stimulus: we1 r4 = 0x55.
  - Required: that cycle rd_pend 0 and rd_data 0x55; next cycle pend_count 0, w1_err 0.
- Set/clear collision:
  - Stimulus: mark r6 and we1 r6 in the same cycle, r6 already pending.
  - Required: r6 stays pending, pend_count unchanged, r6 holds the wdata1 value.
- Error and count:
  - Stimulus: we1 to non-pending r10.
  - Required: w1_err high for exactly one cycle and r10 written.
  - Stimulus: mark all 31 valid registers (DEPTH 32), then clear them in random order.
  - Required: pend_count reaches 31 and returns to 0, matching popcount every cycle.
- Non-power-of-two depth:
  - Stimulus: DEPTH = 24; write and mark address 30.
  - Required: ignored; reads 0, pend 0, pend_count unchanged.
